// File: rtl/uart_frame_parser.sv
// Byte-stream frame parser: HEADER, CMD, LEN, LEN payload bytes, CHK (XOR of CMD, LEN, payload).
// Optional inter-byte timeout is compiled in when FRAME_TIMEOUT_EN is defined.
module uart_frame_parser #(
  parameter logic [7:0] HEADER         = 8'h55,
  parameter int         MAX_LEN        = 8,
  parameter int         TIMEOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_done_signal,
  output logic        frame_valid,
  output logic [7:0]  frame_cmd,
  output logic [3:0]  frame_len,
  output logic [63:0] frame_payload,
  output logic        frame_err,
  output logic [1:0]  frame_err_code
);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    LEN,
    PAYLOAD,
    CHK
  } state_t;

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  state_t      r_state;
  logic [7:0]  r_xor;
  logic [7:0]  r_cmd;
  logic [3:0]  r_len;
  logic [3:0]  r_idx;
  logic [63:0] r_shadow;

  logic        w_len_bad;
  logic        w_last_byte;
  logic        w_chk_ok;
  logic [3:0]  w_idx_next;
  logic [7:0]  w_xor_next;
  logic        w_tmo_expire;

  assign w_xor_next  = r_xor ^ rx_data;
  assign w_len_bad   = rx_data > MAX_LEN_B;
  assign w_idx_next  = r_idx + 4'd1;
  assign w_last_byte = (w_idx_next == r_len);
  assign w_chk_ok    = (rx_data == r_xor);

`ifdef FRAME_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] r_tmo_cnt;

  // A strobe in the expiry cycle wins: the byte is parsed and the timeout is dropped.
  assign w_tmo_expire = (r_state != IDLE) && !rx_done_signal && (r_tmo_cnt == TMO_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tmo_cnt <= '0;
    end else if (rx_done_signal || (r_state == IDLE) || w_tmo_expire) begin
      r_tmo_cnt <= '0;
    end else begin
      r_tmo_cnt <= r_tmo_cnt + 16'd1;
    end
  end
`else
  assign w_tmo_expire = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= IDLE;
      r_xor          <= '0;
      r_cmd          <= '0;
      r_len          <= '0;
      r_idx          <= '0;
      r_shadow       <= '0;
      frame_valid    <= 1'b0;
      frame_err      <= 1'b0;
      frame_err_code <= 2'b00;
      frame_cmd      <= '0;
      frame_len      <= '0;
      frame_payload  <= '0;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      if (w_tmo_expire) begin
        frame_err      <= 1'b1;
        frame_err_code <= 2'b11;
        r_state        <= IDLE;
      end else if (rx_done_signal) begin
        case (r_state)
          IDLE: begin
            if (rx_data == HEADER) begin
              r_shadow <= '0;
              r_state  <= CMD;
            end
          end
          CMD: begin
            r_cmd   <= rx_data;
            r_xor   <= rx_data;
            r_state <= LEN;
          end
          LEN: begin
            if (w_len_bad) begin
              frame_err      <= 1'b1;
              frame_err_code <= 2'b01;
              r_state        <= IDLE;
            end else begin
              r_len   <= rx_data[3:0];
              r_xor   <= w_xor_next;
              r_idx   <= '0;
              r_state <= (rx_data == 8'd0) ? CHK : PAYLOAD;
            end
          end
          PAYLOAD: begin
            // A HEADER value here is ordinary payload; there is no resync.
            r_shadow[{r_idx[2:0], 3'b000} +: 8] <= rx_data;
            r_xor <= w_xor_next;
            r_idx <= w_idx_next;
            if (w_last_byte) begin
              r_state <= CHK;
            end
          end
          CHK: begin
            if (w_chk_ok) begin
              frame_valid   <= 1'b1;
              frame_cmd     <= r_cmd;
              frame_len     <= r_len;
              frame_payload <= r_shadow;
            end else begin
              frame_err      <= 1'b1;
              frame_err_code <= 2'b10;
            end
            r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Scoreboard bench for uart_frame_parser: directed vectors plus randomized frames
// judged by a byte-list reference model; a negedge monitor pops and compares events.
module tb_uart_frame_parser;

  localparam logic [7:0] HDR = 8'h55;
  localparam int MAXL = 8;
  localparam int TMO  = 1000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_done_signal = 1'b0;
  logic        frame_valid;
  logic [7:0]  frame_cmd;
  logic [3:0]  frame_len;
  logic [63:0] frame_payload;
  logic        frame_err;
  logic [1:0]  frame_err_code;

  uart_frame_parser #(
    .HEADER(HDR),
    .MAX_LEN(MAXL),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx_data(rx_data),
    .rx_done_signal(rx_done_signal),
    .frame_valid(frame_valid),
    .frame_cmd(frame_cmd),
    .frame_len(frame_len),
    .frame_payload(frame_payload),
    .frame_err(frame_err),
    .frame_err_code(frame_err_code)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_err;
    logic [1:0]  code;
    logic [7:0]  cmd;
    logic [3:0]  len;
    logic [63:0] payload;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int n_events = 0;

  // Reference state: outputs of the last good frame and last error code.
  logic [7:0]  m_cmd = 8'h00;
  logic [3:0]  m_len = 4'h0;
  logic [63:0] m_payload = 64'h0;
  logic [1:0]  m_code = 2'b00;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst && (frame_valid || frame_err)) begin
      n_events++;
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_event: got valid=%0b err=%0b code=%0b expected no event (cyc %0d)",
                 frame_valid, frame_err, frame_err_code, cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        $display("event %0d: valid=%0b err=%0b code=%0b cmd=%02h len=%0d payload=%016h cyc=%0d",
                 n_events, frame_valid, frame_err, frame_err_code, frame_cmd, frame_len,
                 frame_payload, cyc);
        check("event_kind", 64'({frame_valid, frame_err}), 64'(e.is_err ? 2'b01 : 2'b10));
        check("event_cycle", 64'(cyc), 64'(e.cyc));
        check("frame_cmd", 64'(frame_cmd), 64'(e.cmd));
        check("frame_len", 64'(frame_len), 64'(e.len));
        check("frame_payload", frame_payload, e.payload);
        check("frame_err_code", 64'(frame_err_code), 64'(e.code));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, output int drv_cyc);
    @(posedge clk);
    #1;
    rx_data = b;
    rx_done_signal = 1'b1;
    drv_cyc = cyc;
    @(posedge clk);
    #1;
    rx_done_signal = 1'b0;
    rx_data = 8'($urandom);
  endtask

  // Decide the outcome of a byte list from the frame rules, then drive it and
  // push the expectation when the deciding byte (or the stall) is issued.
  task automatic send_stream(input logic [7:0] bytes[$], input int long_gap_at);
    int h, decide, n, dc, extra;
    logic [7:0] x;
    exp_t e;
    h = -1;
    decide = -1;
    extra = 0;
    e.is_err = 1'b0;
    e.code = 2'b00;
    e.payload = 64'h0;
    for (int i = 0; i < bytes.size(); i++)
      if (h < 0 && bytes[i] == HDR) h = i;
    if (h >= 0 && bytes.size() > h + 2) begin
      n = int'(bytes[h+2]);
      if (n > MAXL) begin
        decide = h + 2;
        e.is_err = 1'b1;
        e.code = 2'b01;
      end else if (bytes.size() > h + 3 + n) begin
        decide = h + 3 + n;
        x = 8'h00;
        for (int k = h + 1; k <= h + 2 + n; k++) x ^= bytes[k];
        if (bytes[decide] == x) begin
          for (int k = 0; k < n; k++) e.payload[8*k +: 8] = bytes[h+3+k];
          m_cmd = bytes[h+1];
          m_len = 4'(n);
          m_payload = e.payload;
        end else begin
          e.is_err = 1'b1;
          e.code = 2'b10;
        end
      end
    end
`ifdef FRAME_TIMEOUT_EN
    if (h >= 0 && long_gap_at >= h && (decide < 0 || long_gap_at < decide)) begin
      decide = long_gap_at;
      e.is_err = 1'b1;
      e.code = 2'b11;
      extra = TMO;
    end
`endif
    if (e.is_err) m_code = e.code;
    e.cmd = m_cmd;
    e.len = m_len;
    e.payload = m_payload;
    e.code = m_code;
    for (int i = 0; i < bytes.size(); i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      send_byte(bytes[i], dc);
      if (i == decide) begin
        e.cyc = dc + 1 + extra;
        sb_q.push_back(e);
      end
      if (i == long_gap_at) repeat (TMO + 100) @(posedge clk);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    rx_done_signal = 1'b0;
    #2;
    check("rst_valid", 64'(frame_valid), 64'h0);
    check("rst_err", 64'(frame_err), 64'h0);
    check("rst_code", 64'(frame_err_code), 64'h0);
    check("rst_cmd", 64'(frame_cmd), 64'h0);
    check("rst_len", 64'(frame_len), 64'h0);
    check("rst_payload", frame_payload, 64'h0);
    m_cmd = 8'h00;
    m_len = 4'h0;
    m_payload = 64'h0;
    m_code = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    #200000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] q[$];
    logic [7:0] v, xr;
    int len, kind;

    do_reset();

    send_stream('{8'h55, 8'h01, 8'h02, 8'hA5, 8'h5A, 8'hFC}, -1);
    send_stream('{8'h55, 8'h07, 8'h00, 8'h07}, -1);
    send_stream('{8'h55, 8'h01, 8'h01, 8'h33, 8'h00}, -1);
    send_stream('{8'h55, 8'h01, 8'h09}, -1);
    send_stream('{8'h55, 8'h02, 8'h01, 8'h55, 8'h56}, -1);
    send_stream('{8'h12, 8'h34, 8'h55, 8'h03, 8'h01, 8'hAA, 8'hA8}, -1);
    send_stream('{8'h55, 8'h01, 8'h02, 8'hA5, 8'h5A, 8'hFC}, 1);

    // Mid-frame reset: partial frame is discarded and outputs return to zero.
    send_stream('{8'h55, 8'h01, 8'h02, 8'hA5}, -1);
    repeat (5) @(posedge clk);
    do_reset();
    send_stream('{8'h55, 8'h01, 8'h02, 8'hA5, 8'h5A, 8'hFC}, -1);

    for (int r = 0; r < 60; r++) begin
      q = {};
      repeat ($urandom_range(0, 2)) begin
        v = 8'($urandom);
        if (v == HDR) v = v ^ 8'h01;
        q.push_back(v);
      end
      q.push_back(HDR);
      v = 8'($urandom);
      q.push_back(v);
      xr = v;
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        q.push_back(8'($urandom_range(MAXL + 1, 255)));
      end else begin
        len = $urandom_range(0, MAXL);
        q.push_back(8'(len));
        xr ^= 8'(len);
        for (int k = 0; k < len; k++) begin
          v = ($urandom_range(0, 3) == 0) ? HDR : 8'($urandom);
          q.push_back(v);
          xr ^= v;
        end
        if (kind == 1) xr ^= 8'($urandom_range(1, 255));
        q.push_back(xr);
      end
      send_stream(q, -1);
    end

    repeat (20) @(posedge clk);
    check("scoreboard_drained", 64'(sb_q.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_frame_parser.md
UART_FRAME_PARSER -- requirements
Module: uart_frame_parser

Interface
REQ-001 SHALL have parameter HEADER, default 8'h55, frame start byte.
REQ-002 SHALL have parameter MAX_LEN, default 8, maximum payload bytes (1..8).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1000, inter-byte timeout in clk cycles (16-bit counter).
REQ-004 SHALL have port clk  in  1  system clock; all logic on rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port rx_data  in  8  received byte from rx_uart.
REQ-007 SHALL have port rx_done_signal  in  1  one-cycle strobe; rx_data valid this cycle.
REQ-008 SHALL have port frame_valid  out  1  one-cycle pulse, good frame latched.
REQ-009 SHALL have port frame_cmd  out  8  command byte of last good frame.
REQ-010 SHALL have port frame_len  out  4  payload length of last good frame.
REQ-011 SHALL have port frame_payload  out  64  payload; byte i at [8i+7:8i], unused bytes zero.
REQ-012 SHALL have port frame_err  out  1  one-cycle pulse, frame discarded.
REQ-013 SHALL have port frame_err_code  out  2  01 bad length, 10 checksum, 11 timeout; held until next error.

Function
REQ-014 SHALL implement frame format: HEADER, CMD, LEN, LEN payload bytes, CHK; CHK = XOR of CMD, LEN and all payload bytes.
REQ-015 SHALL use states IDLE, CMD, LEN, PAYLOAD, CHK; bytes advance state only on rx_done_signal.
REQ-016 IDLE: byte == HEADER -> CMD; any other byte ignored silently, no error.
REQ-017 CMD: store byte, init running XOR to it -> LEN.
REQ-018 LEN: LEN > MAX_LEN -> frame_err, code 01, -> IDLE; LEN == 0 -> CHK; else -> PAYLOAD, byte index 0.
REQ-019 PAYLOAD: write byte to shadow buffer at index, XOR into checksum; after LEN-th byte -> CHK.
REQ-020 CHK: byte == running XOR -> frame_valid; else frame_err, code 10; both -> IDLE.
REQ-021 frame_valid SHALL assert the cycle after the CHK strobe; frame_cmd/len/payload update that same cycle and hold until the next good frame.
REQ-022 Shadow buffer SHALL be cleared on entry to CMD so unused payload bytes read zero.
REQ-023 Failed frames SHALL never alter frame_cmd, frame_len, frame_payload.
REQ-024 frame_err SHALL assert the cycle after the offending strobe (or timeout expiry).
REQ-025 A HEADER byte received mid-frame SHALL be treated as data, not resync.
REQ-026 frame_valid and frame_err SHALL never assert in the same cycle.

Reset
REQ-027 rst low SHALL immediately force state IDLE, frame_valid 0, frame_err 0, frame_err_code 0, frame_cmd 0, frame_len 0, frame_payload 0, timeout counter 0.
REQ-028 Reset mid-frame SHALL discard the partial frame without error pulse; first post-reset byte is evaluated in IDLE.

Configuration
REQ-029 Macro FRAME_TIMEOUT_EN defined: counter runs in any non-IDLE state, clears on each rx_done_signal; reaching TIMEOUT_CYCLES -> frame_err, code 11, -> IDLE; a strobe coinciding with expiry SHALL be processed and the timeout suppressed.
REQ-030 Macro FRAME_TIMEOUT_EN undefined: no counter logic; parser waits indefinitely mid-frame; code 11 never produced.

Verification
REQ-031 Bytes 55 01 02 A5 5A FC -> one frame_valid, frame_cmd 01, frame_len 2, frame_payload 64'h5AA5.
REQ-032 Bytes 55 07 00 07 -> frame_valid, frame_len 0, frame_payload 0; then 55 01 01 33 00 -> frame_err code 10, outputs still cmd 07/len 0.
REQ-033 Bytes 55 01 09 -> frame_err code 01 after LEN byte; following 55 02 01 55 56 -> frame_valid, payload 8'h55.
REQ-034 Bytes 12 34 55 03 01 AA A8 -> junk ignored, frame_valid, cmd 03, payload AA.
REQ-035 FRAME_TIMEOUT_EN: 55 01 then idle 1000 cycles -> frame_err code 11; without macro -> no error, next 02 A5 5A FC completes frame.
REQ-036 rst low after 55 01 02 A5, release, send full frame of REQ-031 -> no error pulse, one frame_valid with REQ-031 values.
